// File: rtl/sequence_marker_pkg.sv
// Shared constants and state encoding for the sequence_marker block.
// The optional sequence field is enabled by defining SEQUENCE_MARKER_SEQ_EN.
package sequence_marker_pkg;

    localparam int BURST_WORDS_DEF = 8192;
    localparam int SEQ_SHIFT_DEF   = 16;
    localparam int BURST_CNT_W     = 13;
    localparam int SEQ_W           = 6;
    localparam int DATA_W          = 10;
    localparam int WORD_W          = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        BURST = 2'd2,
        GAP   = 2'd3
    } state_e;

endpackage

// File: rtl/sequence_marker_counter.sv
// Word counter plus 6-bit sequence number; seq steps each time the
// SEQ_SHIFT-bit word counter wraps. Only built with SEQUENCE_MARKER_SEQ_EN.
module sequence_marker_counter
    import sequence_marker_pkg::*;
#(
    parameter int SEQ_SHIFT = SEQ_SHIFT_DEF
) (
    input  logic             clock,
    input  logic             nReset,
    input  logic             clear,
    input  logic             advance,
    output logic [SEQ_W-1:0] seq
);

    logic [SEQ_SHIFT-1:0] word_count_q, word_count_d;
    logic [SEQ_W-1:0]     seq_q, seq_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        word_count_d = word_count_q;
        seq_d        = seq_q;
        if (clear) begin
            word_count_d = '0;
            seq_d        = '0;
        end else if (advance) begin
            word_count_d = word_count_q + SEQ_SHIFT'(1);
            if (word_count_d == '0) begin
                seq_d = seq_q + SEQ_W'(1);
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            word_count_q <= '0;
            seq_q        <= '0;
        end else begin
            word_count_q <= word_count_d;
            seq_q        <= seq_d;
        end
    end

    assign seq = seq_q;

endmodule

// File: rtl/sequence_marker.sv
// Marks FIFO samples for the FX3 bus and flags bursts cut short.
// Define SEQUENCE_MARKER_SEQ_EN to put the running sequence number in dataOut[15:10].
module sequence_marker
    import sequence_marker_pkg::*;
#(
    parameter int BURST_WORDS = BURST_WORDS_DEF,
    parameter int SEQ_SHIFT   = SEQ_SHIFT_DEF
) (
    input  logic              clock,
    input  logic              nReset,
    input  logic              collectData,
    input  logic              readData,
    input  logic [DATA_W-1:0] dataIn,
    output logic [WORD_W-1:0] dataOut,
    output logic              burstError
);

    localparam logic [BURST_CNT_W-1:0] BURST_LAST = BURST_CNT_W'(BURST_WORDS - 1);

    state_e                 state_q, state_d;
    logic [BURST_CNT_W-1:0] burst_count_q, burst_count_d;
    logic [WORD_W-1:0]      data_out_q, data_out_d;
    logic                   burst_error_q, burst_error_d;
    logic                   accept;
    logic [SEQ_W-1:0]       seq;

    // A word is taken whenever the FX3 samples while capture is live and not idle.
    assign accept = collectData && readData && (state_q != IDLE);

`ifdef SEQUENCE_MARKER_SEQ_EN
    logic clear_seq;
    assign clear_seq = !collectData || (state_q == IDLE);

    sequence_marker_counter #(
        .SEQ_SHIFT (SEQ_SHIFT)
    ) u_counter (
        .clock   (clock),
        .nReset  (nReset),
        .clear   (clear_seq),
        .advance (accept),
        .seq     (seq)
    );
`else
    // SEQ_SHIFT only sizes the counter, which this build leaves out.
    if (SEQ_SHIFT >= 0) begin : g_no_seq
        assign seq = '0;
    end
`endif

    always_comb begin
        state_d       = state_q;
        burst_count_d = burst_count_q;
        data_out_d    = data_out_q;
        burst_error_d = burst_error_q;

        if (accept) begin
            data_out_d    = {seq, dataIn};
            burst_count_d = (burst_count_q == BURST_LAST) ? '0
                                                          : burst_count_q + BURST_CNT_W'(1);
        end

        if (!collectData) begin
            state_d       = IDLE;
            burst_count_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d       = ARMED;
                    burst_count_d = '0;
                    burst_error_d = 1'b0;
                end
                ARMED: if (readData) state_d = BURST;
                BURST: begin
                    if (!readData) begin
                        state_d = GAP;
                        if (burst_count_q != '0) begin
                            burst_error_d = 1'b1;
                            burst_count_d = '0;
                        end
                    end
                end
                GAP:     if (readData) state_d = BURST;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_q       <= IDLE;
            burst_count_q <= '0;
            data_out_q    <= '0;
            burst_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            burst_count_q <= burst_count_d;
            data_out_q    <= data_out_d;
            burst_error_q <= burst_error_d;
        end
    end

    assign dataOut    = data_out_q;
    assign burstError = burst_error_q;

endmodule

// File: tb/tb_sequence_marker.sv
// Directed bench for sequence_marker: default-size instance plus a small
// instance (16-word bursts, 16-word seq step) used to reach the seq wrap quickly.
module tb_sequence_marker;
    import sequence_marker_pkg::*;

`ifdef SEQUENCE_MARKER_SEQ_EN
    localparam bit SEQ_EN = 1'b1;
`else
    localparam bit SEQ_EN = 1'b0;
`endif

    logic        clock;
    logic        nReset;
    logic        collectData, readData;
    logic [9:0]  dataIn;
    logic [15:0] dataOut;
    logic        burstError;

    logic        s_collect, s_read;
    logic [9:0]  s_data;
    logic [15:0] s_out;
    logic        s_err;

    int total;
    int bad;

    int unsigned widx;
    int unsigned widx_s;
    logic        mm_seen;
    logic [15:0] mm_got, mm_exp;

    sequence_marker dut (
        .clock       (clock),
        .nReset      (nReset),
        .collectData (collectData),
        .readData    (readData),
        .dataIn      (dataIn),
        .dataOut     (dataOut),
        .burstError  (burstError)
    );

    sequence_marker #(.BURST_WORDS(16), .SEQ_SHIFT(4)) dut_s (
        .clock       (clock),
        .nReset      (nReset),
        .collectData (s_collect),
        .readData    (s_read),
        .dataIn      (s_data),
        .dataOut     (s_out),
        .burstError  (s_err)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] mark(input int unsigned idx, input int shift,
                                         input logic [9:0] d);
        logic [5:0] s;
        s = 6'((idx >> shift) & 32'd63);
        return {(SEQ_EN ? s : 6'd0), d};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drives n consecutive sampled words into the main instance, noting the first bad word.
    task automatic drive_words(input int n, input logic [9:0] d);
        logic [15:0] want;
        readData = 1'b1;
        dataIn   = d;
        for (int i = 0; i < n; i++) begin
            tick();
            want = mark(widx, 16, d);
            if (!mm_seen && dataOut !== want) begin
                mm_seen = 1'b1;
                mm_got  = dataOut;
                mm_exp  = want;
            end
            widx++;
        end
    endtask

    task automatic drive_words_s(input int n, input logic [9:0] d);
        logic [15:0] want;
        s_read = 1'b1;
        s_data = d;
        for (int i = 0; i < n; i++) begin
            tick();
            want = mark(widx_s, 4, d);
            if (!mm_seen && s_out !== want) begin
                mm_seen = 1'b1;
                mm_got  = s_out;
                mm_exp  = want;
            end
            widx_s++;
        end
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        collectData = 1'b1;
        readData = 1'b1;
        dataIn = 10'h3AB;
        repeat (3) tick();
        total++;
        if (dataOut !== 16'h0000) begin bad++; $display("FAIL reset_dataOut got=%h want=0000", dataOut); end
        total++;
        if (burstError !== 1'b0) begin bad++; $display("FAIL reset_burstError got=%b want=0", burstError); end
        total++;
        if (dut.state_q !== IDLE) begin bad++; $display("FAIL reset_state got=%0d want=%0d", dut.state_q, IDLE); end
        collectData = 1'b0;
        readData = 1'b0;
        tick();
        nReset = 1'b1;
        tick();
    endtask

    task automatic test_full_burst();
        widx = 0;
        mm_seen = 1'b0;
        collectData = 1'b1;
        tick();
        drive_words(8192, 10'h155);
        total++;
        if (mm_seen) begin bad++; $display("FAIL full_burst_words got=%h want=%h", mm_got, mm_exp); end
        readData = 1'b0;
        dataIn = 10'h2AA;
        tick();
        total++;
        if (burstError !== 1'b0) begin bad++; $display("FAIL full_burst_error got=%b want=0", burstError); end
        total++;
        if (dut.state_q !== GAP) begin bad++; $display("FAIL full_burst_state got=%0d want=%0d", dut.state_q, GAP); end
        repeat (2) tick();
        total++;
        if (dataOut !== 16'h0155) begin bad++; $display("FAIL hold_when_idle_bus got=%h want=0155", dataOut); end
    endtask

    task automatic test_short_burst();
        collectData = 1'b0;
        tick();
        collectData = 1'b1;
        tick();
        widx = 0;
        mm_seen = 1'b0;
        drive_words(100, 10'h0AA);
        readData = 1'b0;
        tick();
        total++;
        if (burstError !== 1'b1) begin bad++; $display("FAIL short_burst_error got=%b want=1", burstError); end
        total++;
        if (dut.state_q !== GAP) begin bad++; $display("FAIL short_burst_state got=%0d want=%0d", dut.state_q, GAP); end
        drive_words(8192, 10'h1C3);
        readData = 1'b0;
        tick();
        total++;
        if (mm_seen) begin bad++; $display("FAIL after_short_words got=%h want=%h", mm_got, mm_exp); end
        total++;
        if (burstError !== 1'b1) begin bad++; $display("FAIL error_sticky got=%b want=1", burstError); end
        collectData = 1'b0;
        tick();
        total++;
        if (burstError !== 1'b1) begin bad++; $display("FAIL error_held_in_idle got=%b want=1", burstError); end
        collectData = 1'b1;
        tick();
        total++;
        if (burstError !== 1'b0) begin bad++; $display("FAIL error_clear_on_arm got=%b want=0", burstError); end
    endtask

    task automatic test_collect_drop();
        widx = 0;
        mm_seen = 1'b0;
        drive_words(50, 10'h077);
        readData = 1'b0;
        collectData = 1'b0;
        tick();
        total++;
        if (dut.state_q !== IDLE) begin bad++; $display("FAIL collect_drop_state got=%0d want=%0d", dut.state_q, IDLE); end
        total++;
        if (burstError !== 1'b0) begin bad++; $display("FAIL collect_drop_error got=%b want=0", burstError); end
        collectData = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_burst();
        widx = 0;
        mm_seen = 1'b0;
        drive_words(300, 10'h123);
        nReset = 1'b0;
        #1;
        total++;
        if (dataOut !== 16'h0000) begin bad++; $display("FAIL async_reset_dataOut got=%h want=0000", dataOut); end
        readData = 1'b0;
        collectData = 1'b0;
        tick();
        nReset = 1'b1;
        tick();
        collectData = 1'b1;
        tick();
        widx = 0;
        mm_seen = 1'b0;
        drive_words(8192, 10'h3FF);
        readData = 1'b0;
        tick();
        total++;
        if (burstError !== 1'b0) begin bad++; $display("FAIL post_reset_burst_error got=%b want=0", burstError); end
    endtask

    task automatic test_seq_advance();
        for (int b = 1; b < 8; b++) begin
            drive_words(8192, 10'h3FF);
            readData = 1'b0;
            tick();
        end
        total++;
        if (burstError !== 1'b0) begin bad++; $display("FAIL eight_bursts_error got=%b want=0", burstError); end
        total++;
        if (dut.state_q !== GAP) begin bad++; $display("FAIL eight_bursts_state got=%0d want=%0d", dut.state_q, GAP); end
        drive_words(1, 10'h3FF);
        total++;
        if (mm_seen) begin bad++; $display("FAIL long_run_words got=%h want=%h", mm_got, mm_exp); end
        total++;
        if (dataOut[15:10] !== (SEQ_EN ? 6'd1 : 6'd0)) begin
            bad++;
            $display("FAIL seq_after_65536 got=%0d want=%0d", dataOut[15:10], (SEQ_EN ? 1 : 0));
        end
    endtask

    task automatic test_seq_wrap();
        widx_s = 0;
        mm_seen = 1'b0;
        s_collect = 1'b1;
        tick();
        for (int b = 0; b < 64; b++) begin
            drive_words_s(16, 10'h2C5);
            if (b == 63) begin
                total++;
                if (s_out[15:10] !== (SEQ_EN ? 6'd63 : 6'd0)) begin
                    bad++;
                    $display("FAIL seq_before_wrap got=%0d want=%0d", s_out[15:10], (SEQ_EN ? 63 : 0));
                end
            end
            s_read = 1'b0;
            tick();
        end
        drive_words_s(1, 10'h2C5);
        total++;
        if (s_out !== 16'h02C5) begin bad++; $display("FAIL seq_wrap_word got=%h want=02c5", s_out); end
        total++;
        if (mm_seen) begin bad++; $display("FAIL seq_wrap_words got=%h want=%h", mm_got, mm_exp); end
        total++;
        if (s_err !== 1'b0) begin bad++; $display("FAIL seq_wrap_error got=%b want=0", s_err); end
    endtask

    initial begin
        clock = 1'b0;
        nReset = 1'b0;
        collectData = 1'b0;
        readData = 1'b0;
        dataIn = '0;
        s_collect = 1'b0;
        s_read = 1'b0;
        s_data = '0;
        total = 0;
        bad = 0;
        widx = 0;
        widx_s = 0;
        mm_seen = 1'b0;
        mm_got = '0;
        mm_exp = '0;

        test_reset();
        test_full_burst();
        test_short_burst();
        test_collect_drop();
        test_reset_mid_burst();
        test_seq_advance();
        test_seq_wrap();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sequence_marker.md
SEQUENCE_MARKER -- requirements
Module: sequenceMarker

Interface
REQ-001 SHALL have parameter BURST_WORDS, default 8192, meaning words per FX3 read burst.
REQ-002 SHALL have parameter SEQ_SHIFT, default 16, meaning sequence number advances every 2^SEQ_SHIFT words.
REQ-003 SHALL have port clock, input, 1, meaning FX3 clock at 60 MHz; the only clock.
REQ-004 SHALL have port nReset, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port collectData, input, 1, meaning capture enable from FX3.
REQ-006 SHALL have port readData, input, 1, meaning FX3 is sampling the bus this cycle (fx3isReading).
REQ-007 SHALL have port dataIn, input, 10, meaning unsigned sample from the FIFO buffer output.
REQ-008 SHALL have port dataOut, output, 16, meaning marked word for the FX3 databus.
REQ-009 SHALL have port burstError, output, 1, meaning sticky short-burst flag.

Function
REQ-010 SHALL implement FSM states IDLE, ARMED, BURST and GAP.
REQ-011 SHALL move IDLE->ARMED when collectData=1.
REQ-012 SHALL move ARMED->BURST on the first readData=1.
REQ-013 SHALL move BURST->GAP when readData falls and burstCount=0.
REQ-014 SHALL move GAP->BURST when readData=1.
REQ-015 SHALL move any state->IDLE when collectData=0; this takes priority over all other transitions.
REQ-016 SHALL, in BURST, and in ARMED/GAP on the cycle readData rises, register dataOut<={seq[5:0],dataIn[9:0]} with 1-cycle latency.
REQ-017 SHALL hold dataOut while readData=0.
REQ-018 SHALL keep a 13-bit burstCount that increments per accepted word and wraps BURST_WORDS-1->0.
REQ-019 SHALL keep a wordCount of SEQ_SHIFT bits; on wrap to 0, seq increments.
REQ-020 SHALL wrap seq from 63 to 0 with no flag.
REQ-021 SHALL, if readData falls in BURST with burstCount!=0, set burstError=1 and go to GAP with burstCount cleared.
REQ-022 SHALL clear burstError only on the IDLE->ARMED transition.
REQ-023 SHALL, in IDLE, clear burstCount, wordCount and seq, and ignore readData.
REQ-024 SHALL treat collectData falling on the same cycle as readData falling mid-burst as IDLE with no error.

Reset
REQ-025 SHALL, while nReset=0, force state=IDLE, dataOut=16'h0000, burstError=0 and all counters=0, asynchronously.
REQ-026 SHALL deassert reset synchronously to clock.
REQ-027 SHALL, on reset mid-burst, discard the partial burst and raise no error.

Configuration
REQ-028 SHALL use the macro SEQUENCE_MARKER_SEQ_EN.
REQ-029 SHALL, with SEQUENCE_MARKER_SEQ_EN defined, place seq in dataOut[15:10].
REQ-030 SHALL, without SEQUENCE_MARKER_SEQ_EN, drive dataOut[15:10]=0.
REQ-031 SHALL, without SEQUENCE_MARKER_SEQ_EN, synthesise no seq or wordCount logic.
REQ-032 SHALL leave burst checking identical in both builds.

Structure
REQ-033 SHALL hold BURST_WORDS, SEQ_SHIFT defaults, the state encoding and the 6-bit seq width as shared constants in the project package/include.
REQ-034 SHALL have one sub-module, markerCounter (wordCount+seq with wrap), instantiated once.

Verification
REQ-035 SHALL cover: collectData=1, readData high 8192 cycles, dataIn=10'h155 -> dataOut=16'h0155 throughout (seq=0), burstError=0, state GAP.
REQ-036 SHALL cover: 8 bursts of 8192 words (65536 total) then one more word -> last word seq=1, i.e. dataOut[15:10]=6'd1.
REQ-037 SHALL cover: readData drops after 100 words -> burstError=1 next cycle and stays set through the following full burst; collectData toggle 0->1 -> burstError=0.
REQ-038 SHALL cover: 64*65536 words -> seq wraps 63->0, dataOut[15:10]=0.
REQ-039 SHALL cover: nReset asserted mid-burst between clock edges -> dataOut=0 immediately; after release a full burst yields no error.
REQ-040 SHALL cover: build without SEQUENCE_MARKER_SEQ_EN, 65537 words of 10'h3FF -> dataOut=16'h03FF on every word.
